// File: rtl/bridge_mux_if.sv
// bridge_mux_if -- bundles the processor-side and device-side signals of
// the bridge into one interface.
//   slave  : the bridge's view (takes processor requests, drives devices)
//   master : the surrounding system's view (processor plus device models)
// Signals:
//   PrReq/PrAddr/PrWD/PrWE  processor request, address, write data, direction
//   PrRD/PrReady/PrErr      registered read data, completion pulse, error flag
//   DEV_Addr/DEV_WD         latched address and write data, broadcast
//   DEV_Sel/DEV_WE          one-hot select and per-device write enable
//   DEV_Ack/DEV_RD          per-device completion and packed read data
interface bridge_mux_if #(
  parameter int NDEV = 4
);
  logic                 PrReq;
  logic [31:0]          PrAddr;
  logic [31:0]          PrWD;
  logic                 PrWE;
  logic [31:0]          PrRD;
  logic                 PrReady;
  logic                 PrErr;
  logic [31:0]          DEV_Addr;
  logic [31:0]          DEV_WD;
  logic [NDEV-1:0]      DEV_Sel;
  logic [NDEV-1:0]      DEV_WE;
  logic [NDEV-1:0]      DEV_Ack;
  logic [NDEV*32-1:0]   DEV_RD;

  modport slave (
    input  PrReq, PrAddr, PrWD, PrWE, DEV_Ack, DEV_RD,
    output PrRD, PrReady, PrErr, DEV_Addr, DEV_WD, DEV_Sel, DEV_WE
  );

  modport master (
    output PrReq, PrAddr, PrWD, PrWE, DEV_Ack, DEV_RD,
    input  PrRD, PrReady, PrErr, DEV_Addr, DEV_WD, DEV_Sel, DEV_WE
  );
endinterface

// File: rtl/bridge_mux.sv
// bridge_mux -- single-master to NDEV-device bridge. A processor request is
// latched in IDLE, decoded on PrAddr[15:4] against BASE_HI+i, and forwarded
// to the matching device until it acks. Misses complete with PrErr.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      bridge_mux_if.slave (processor and device signals)
// Parameters: NDEV (1..8), BASE_HI (PrAddr[15:4] of device 0), TIMEOUT (1..255)
// Optional feature: define BRIDGE_TIMEOUT_EN to abort an ACCESS that sees no
// ack for TIMEOUT cycles; without it ACCESS waits for ack indefinitely.
//
// state  | meaning
// IDLE   | waiting for PrReq; latches request and decodes on the accepting edge
// ACCESS | device selected, waiting for its ack
// DONE   | one-cycle PrReady, PrErr=0
// ERR    | one-cycle PrReady with PrErr=1 (decode miss or timeout), PrRD=0
module bridge_mux #(
  parameter int          NDEV    = 4,
  parameter logic [11:0] BASE_HI = 12'h7F0,
  parameter int          TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset_n,
  bridge_mux_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  state_t            state, state_nxt;
  logic [NDEV-1:0]   hit_vec;
  logic [NDEV-1:0]   sel_q;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wd_q;
  logic [31:0]       rd_q;
  logic              ack_sel;
  logic [31:0]       rd_sel;
  logic              tmo_hit;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (bus.PrAddr[15:4] == BASE_HI + 12'(i)) hit_vec[i] = 1'b1;
    end
  end

  // Only the selected device's ack and read data matter.
  assign ack_sel = |(bus.DEV_Ack & sel_q);

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (sel_q[i]) rd_sel = bus.DEV_RD[32*i +: 32];
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // ACCESS is only entered from IDLE, so clearing in IDLE clears on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS && !ack_sel) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // True on the edge where the counter would reach TIMEOUT.
  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.PrReq) state_nxt = (|hit_vec) ? ACCESS : ERR;
      end
      ACCESS: begin
        // ack has priority over a timeout on the same edge
        if (ack_sel)      state_nxt = DONE;
        else if (tmo_hit) state_nxt = ERR;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      rd_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.PrReq) begin
            addr_q <= bus.PrAddr;
            wd_q   <= bus.PrWD;
            we_q   <= bus.PrWE;
            sel_q  <= hit_vec;
            if (!(|hit_vec)) rd_q <= '0;
          end
        end
        ACCESS: begin
          if (ack_sel) begin
            if (!we_q) rd_q <= rd_sel;
          end else if (tmo_hit) begin
            rd_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.PrRD     = rd_q;
  assign bus.PrReady  = (state == DONE) || (state == ERR);
  assign bus.PrErr    = (state == ERR);
  assign bus.DEV_Addr = addr_q;
  assign bus.DEV_WD   = wd_q;
  assign bus.DEV_Sel  = (state == ACCESS) ? sel_q : '0;
  assign bus.DEV_WE   = (state == ACCESS && we_q) ? sel_q : '0;

endmodule

// File: tb/tb_bridge_mux.sv
// tb_bridge_mux -- directed tests for bridge_mux with hand-computed results.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_bridge_mux;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  bridge_mux_if #(.NDEV(4)) bus();

  bridge_mux #(
    .NDEV    (4),
    .BASE_HI (12'h7F0),
    .TIMEOUT (15)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int       we_cnt;
    int       rdy_cnt;
    logic     seen;
    logic [8:0] rdy_pat;
    logic [8:0] sel_pat;

    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b1;
    bus.PrReq   = 1'b0;
    bus.PrAddr  = '0;
    bus.PrWD    = '0;
    bus.PrWE    = 1'b0;
    bus.DEV_Ack = '0;
    bus.DEV_RD  = '0;

    // reset values
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.PrReady), 32'd0);
    chk("rst_err",   32'(bus.PrErr),   32'd0);
    chk("rst_rd",    bus.PrRD,         32'd0);
    chk("rst_addr",  bus.DEV_Addr,     32'd0);
    chk("rst_wd",    bus.DEV_WD,       32'd0);
    chk("rst_sel",   32'(bus.DEV_Sel), 32'd0);
    chk("rst_we",    32'(bus.DEV_WE),  32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // read dev1, immediate ack
    bus.DEV_RD  = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
    bus.PrAddr  = 32'h0000_7F14;
    bus.PrWE    = 1'b0;
    bus.PrReq   = 1'b1;
    bus.DEV_Ack = 4'b0010;
    tick();
    bus.PrReq = 1'b0;
    chk("rd_sel_c1",   32'(bus.DEV_Sel), 32'h2);
    chk("rd_we_c1",    32'(bus.DEV_WE),  32'h0);
    chk("rd_addr_c1",  bus.DEV_Addr,     32'h0000_7F14);
    chk("rd_ready_c1", 32'(bus.PrReady), 32'd0);
    tick();
    chk("rd_ready_c2", 32'(bus.PrReady), 32'd1);
    chk("rd_err_c2",   32'(bus.PrErr),   32'd0);
    chk("rd_data_c2",  bus.PrRD,         32'hDEAD_BEEF);
    chk("rd_sel_c2",   32'(bus.DEV_Sel), 32'h0);
    bus.DEV_Ack = '0;
    tick();
    chk("rd_ready_c3", 32'(bus.PrReady), 32'd0);

    // write dev3, three wait cycles; unselected acks must be ignored
    bus.DEV_RD[32*3 +: 32] = 32'hCAFE_F00D;
    bus.PrAddr  = 32'h0000_7F30;
    bus.PrWD    = 32'h1234_5678;
    bus.PrWE    = 1'b1;
    bus.PrReq   = 1'b1;
    bus.DEV_Ack = 4'b0111;
    tick();
    bus.PrReq  = 1'b0;
    bus.PrAddr = '0;
    bus.PrWD   = '0;
    bus.PrWE   = 1'b0;
    we_cnt  = 0;
    rdy_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 4) bus.DEV_Ack = 4'b1000;
      if (c == 1) begin
        chk("wr_wd",   bus.DEV_WD,   32'h1234_5678);
        chk("wr_addr", bus.DEV_Addr, 32'h0000_7F30);
      end
      if (bus.DEV_WE == 4'b1000) we_cnt++;
      if (bus.PrReady) begin
        rdy_cnt++;
        chk("wr_err",  32'(bus.PrErr), 32'd0);
        chk("wr_prrd", bus.PrRD,       32'hDEAD_BEEF);
      end
      tick();
    end
    bus.DEV_Ack = '0;
    chk("wr_we_cycles", 32'(we_cnt),  32'd4);
    chk("wr_ready_cnt", 32'(rdy_cnt), 32'd1);

    // decode miss above the last window, write direction
    bus.PrAddr = 32'h0000_7F50;
    bus.PrWE   = 1'b1;
    bus.PrReq  = 1'b1;
    tick();
    bus.PrReq = 1'b0;
    seen = (|bus.DEV_Sel) | (|bus.DEV_WE);
    chk("miss_ready", 32'(bus.PrReady), 32'd1);
    chk("miss_err",   32'(bus.PrErr),   32'd1);
    chk("miss_rd",    bus.PrRD,         32'd0);
    tick();
    seen = seen | (|bus.DEV_Sel) | (|bus.DEV_WE);
    chk("miss_ready_off", 32'(bus.PrReady), 32'd0);
    chk("miss_no_sel",    32'(seen),        32'd0);

    // upper address bits ignored: dev2
    bus.PrAddr  = 32'hABCD_7F24;
    bus.PrWE    = 1'b0;
    bus.PrReq   = 1'b1;
    bus.DEV_Ack = 4'b0100;
    tick();
    bus.PrReq = 1'b0;
    chk("hi_sel", 32'(bus.DEV_Sel), 32'h4);
    tick();
    chk("hi_rd",  bus.PrRD, 32'h2222_2222);
    chk("hi_err", 32'(bus.PrErr), 32'd0);
    bus.DEV_Ack = '0;
    tick();

    // one window below device 0 misses
    bus.PrAddr = 32'h0000_7EF0;
    bus.PrReq  = 1'b1;
    tick();
    bus.PrReq = 1'b0;
    chk("below_err", 32'(bus.PrErr), 32'd1);
    tick();

`ifdef BRIDGE_TIMEOUT_EN
    // dev0 read, no ack: error after 15 ACCESS cycles
    bus.PrAddr = 32'h0000_7F00;
    bus.PrReq  = 1'b1;
    tick();
    bus.PrReq = 1'b0;
    we_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.PrReady) break;
      if (bus.DEV_Sel != '0) we_cnt++;
      tick();
    end
    chk("tmo_ready",  32'(bus.PrReady), 32'd1);
    chk("tmo_err",    32'(bus.PrErr),   32'd1);
    chk("tmo_cycles", 32'(we_cnt),      32'd15);
    chk("tmo_rd",     bus.PrRD,         32'd0);
    tick();

    // ack in the 15th ACCESS cycle wins
    bus.PrReq = 1'b1;
    tick();
    bus.PrReq = 1'b0;
    for (int c = 1; c <= 14; c++) tick();
    chk("tmo_c15_sel", 32'(bus.DEV_Sel), 32'h1);
    bus.DEV_Ack = 4'b0001;
    tick();
    chk("tmo_ack_ready", 32'(bus.PrReady), 32'd1);
    chk("tmo_ack_err",   32'(bus.PrErr),   32'd0);
    chk("tmo_ack_rd",    bus.PrRD,         32'h1111_1111);
    bus.DEV_Ack = '0;
    tick();
`else
    // without the timeout feature, ACCESS waits for ack indefinitely
    bus.PrAddr = 32'h0000_7F00;
    bus.PrReq  = 1'b1;
    tick();
    bus.PrReq = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      seen = seen | bus.PrReady;
      tick();
    end
    chk("wait_no_ready", 32'(seen),        32'd0);
    chk("wait_sel",      32'(bus.DEV_Sel), 32'h1);
    bus.DEV_Ack = 4'b0001;
    tick();
    chk("wait_ready", 32'(bus.PrReady), 32'd1);
    chk("wait_rd",    bus.PrRD,         32'h1111_1111);
    bus.DEV_Ack = '0;
    tick();
`endif

    // reset in the second ACCESS cycle
    bus.PrAddr = 32'h0000_7F08;
    bus.PrReq  = 1'b1;
    tick();
    bus.PrReq = 1'b0;
    tick();
    chk("ar_sel_before", 32'(bus.DEV_Sel), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("ar_sel",   32'(bus.DEV_Sel),  32'h0);
    chk("ar_addr",  bus.DEV_Addr,      32'd0);
    chk("ar_rd",    bus.PrRD,          32'd0);
    chk("ar_ready", 32'(bus.PrReady),  32'd0);
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen = seen | bus.PrReady;
      tick();
    end
    chk("ar_no_ready", 32'(seen), 32'd0);
    bus.PrAddr  = 32'h0000_7F14;
    bus.PrReq   = 1'b1;
    bus.DEV_Ack = 4'b0010;
    tick();
    bus.PrReq = 1'b0;
    tick();
    chk("ar_next_ready", 32'(bus.PrReady), 32'd1);
    chk("ar_next_rd",    bus.PrRD,         32'hDEAD_BEEF);
    bus.DEV_Ack = '0;
    tick();

    // PrReq held high, ack always present: one transaction every 3 cycles
    bus.PrAddr  = 32'h0000_7F14;
    bus.PrReq   = 1'b1;
    bus.DEV_Ack = 4'b1111;
    rdy_pat = '0;
    sel_pat = '0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      rdy_pat[c] = bus.PrReady;
      sel_pat[c] = |bus.DEV_Sel;
    end
    bus.PrReq   = 1'b0;
    bus.DEV_Ack = '0;
    chk("b2b_ready_pat", 32'(rdy_pat), 32'h124);
    chk("b2b_sel_pat",   32'(sel_pat), 32'h092);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
